mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/cpu_mem_pkg.sv | 20 ++
 rtl/resp_hold_buf.sv | 70 +++++++
 rtl/mem_port_arbiter.sv | 94 +++++++++
 tb/tb_mem_port_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and default widths for the fetch/load-store SRAM arbiter.
package cpu_mem_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 32;
  localparam int unsigned DEFAULT_DATA_W = 32;

  // Which requester owns the outstanding read response.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Response tracking: nothing pending, response presented now, response stalled.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StResp = 2'd1,
    StHold = 2'd2
  } state_e;

endpackage

// File: rtl/resp_hold_buf.sv
// Read response tracker: owner tag, rvalid routing and the stall hold register.
// The SRAM only presents read data for one cycle, so a stalled response is
// captured into r_hold and replayed until the owner accepts it.
module resp_hold_buf #(
  parameter int unsigned DATA_W = cpu_mem_pkg::DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_rd_gnt,
  input  logic              i_gnt_is_d,
  input  logic [DATA_W-1:0] i_sram_rdata,
  input  logic              i_rready_i,
  input  logic              i_rready_d,
  output logic              o_rvalid_i,
  output logic              o_rvalid_d,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_stall
);
  import cpu_mem_pkg::*;

  state_e            r_state;
  state_e            w_state_nxt;
  owner_e            r_owner;
  logic [DATA_W-1:0] r_hold;
  logic              w_rready;
  logic              w_busy;

  // Next state, rvalid routing and grant blocking while a response is unaccepted.
  always_comb begin
    w_state_nxt = r_state;
    w_rready    = (r_owner == OWN_D) ? i_rready_d : i_rready_i;
    w_busy      = (r_state != StIdle);
    o_stall     = w_busy && !w_rready;
    o_rvalid_i  = w_busy && (r_owner == OWN_I);
    o_rvalid_d  = w_busy && (r_owner == OWN_D);
    o_rdata     = (r_state == StHold) ? r_hold : i_sram_rdata;
    unique case (r_state)
      StIdle: begin
        if (i_rd_gnt) w_state_nxt = StResp;
      end
      StResp, StHold: begin
        if (!w_rready)     w_state_nxt = StHold;
        else if (i_rd_gnt) w_state_nxt = StResp;
        else               w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State and owner tag; owner only changes on a read grant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= StIdle;
      r_owner <= OWN_I;
    end else begin
      r_state <= w_state_nxt;
      if (i_rd_gnt) r_owner <= i_gnt_is_d ? OWN_D : OWN_I;
    end
  end

  // Capture the one-cycle SRAM word when its response stalls.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hold <= '0;
    end else if ((r_state == StResp) && !w_rready) begin
      r_hold <= i_sram_rdata;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch read-only, load/store) for a single 1-cycle-latency
// SRAM port. Data wins over fetch; define ARB_STARVE_GUARD_EN to force a fetch
// grant after STARVE_MAX consecutive data grants while fetch is waiting.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = cpu_mem_pkg::DEFAULT_ADDR_W,
  parameter int unsigned DATA_W     = cpu_mem_pkg::DEFAULT_DATA_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              i_rready,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              d_rready,
  output logic              sram_en,
  output logic [3:0]        sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  logic              w_stall;
  logic              w_force_i;
  logic              w_arb_ok;
  logic              w_d_gnt;
  logic              w_i_gnt;
  logic              w_rd_gnt;
  logic [DATA_W-1:0] w_rdata;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  logic [CntW-1:0] r_starve_cnt;

  assign w_force_i = i_req && (r_starve_cnt >= CntW'(STARVE_MAX));

  // Count data grants that pass over a waiting fetch; any fetch grant or idle fetch clears.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_starve_cnt <= '0;
    end else if (!i_req || w_i_gnt) begin
      r_starve_cnt <= '0;
    end else if (w_d_gnt && (r_starve_cnt < CntW'(STARVE_MAX))) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`else
  logic w_unused_starve;
  assign w_force_i       = 1'b0;
  assign w_unused_starve = ^STARVE_MAX;
`endif

  // Arbitration and SRAM drive; reset also gates the combinational grants.
  always_comb begin
    w_arb_ok   = resetn && !w_stall;
    w_d_gnt    = w_arb_ok && d_req && !w_force_i;
    w_i_gnt    = w_arb_ok && i_req && !(d_req && !w_force_i);
    w_rd_gnt   = w_i_gnt || (w_d_gnt && (d_we == 4'h0));
    i_gnt      = w_i_gnt;
    d_gnt      = w_d_gnt;
    sram_en    = w_i_gnt || w_d_gnt;
    sram_we    = w_d_gnt ? d_we : 4'h0;
    sram_addr  = w_d_gnt ? d_addr : i_addr;
    sram_wdata = w_d_gnt ? d_wdata : '0;
    i_rdata    = w_rdata;
    d_rdata    = w_rdata;
  end

  resp_hold_buf #(
    .DATA_W (DATA_W)
  ) u_resp_hold_buf (
    .clk          (clk),
    .resetn       (resetn),
    .i_rd_gnt     (w_rd_gnt),
    .i_gnt_is_d   (w_d_gnt),
    .i_sram_rdata (sram_rdata),
    .i_rready_i   (i_rready),
    .i_rready_d   (d_rready),
    .o_rvalid_i   (i_rvalid),
    .o_rvalid_d   (d_rvalid),
    .o_rdata      (w_rdata),
    .o_stall      (w_stall)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1-cycle SRAM.
// Unwritten SRAM words read as {24'hA50000, word index}; the SRAM output
// inverts on idle cycles so a missing hold register shows up.
module tb_mem_port_arbiter;

  logic        clk;
  logic        resetn;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_rready;
  logic        d_req;
  logic [3:0]  d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_rready;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  int n_total = 0;
  int n_bad   = 0;

  bit [31:0] mem     [256];
  bit        written [256];

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_gnt      (i_gnt),
    .i_rvalid   (i_rvalid),
    .i_rdata    (i_rdata),
    .i_rready   (i_rready),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .d_rready   (d_rready),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (sram_en) begin
      sram_rdata <= written[sram_addr[9:2]] ? mem[sram_addr[9:2]]
                                            : {24'hA50000, sram_addr[9:2]};
      if (sram_we != 4'h0) begin
        for (int b = 0; b < 4; b++) begin
          if (sram_we[b]) mem[sram_addr[9:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
        written[sram_addr[9:2]] <= 1'b1;
      end
    end else begin
      sram_rdata <= ~sram_rdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle's input-drive point.
  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  logic [5:0] exp_i_pat;

  initial begin
    resetn = 1'b0; i_req = 1'b1; i_addr = 32'h1c000000; i_rready = 1'b1;
    d_req = 1'b1; d_we = 4'h0; d_addr = 32'h100; d_wdata = 32'h0; d_rready = 1'b1;
    `ifdef ARB_STARVE_GUARD_EN
    exp_i_pat = 6'b010000;
    `else
    exp_i_pat = 6'b000000;
    `endif

    // Reset: requests high but nothing granted or valid.
    next_cyc(); next_cyc(); settle();
    check("rst_i_gnt", {31'd0, i_gnt}, 32'd0);
    check("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
    check("rst_sram_en", {31'd0, sram_en}, 32'd0);
    check("rst_sram_we", {28'd0, sram_we}, 32'd0);
    check("rst_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);

    // Fetch only, granted the cycle reset releases.
    next_cyc(); resetn = 1'b1; d_req = 1'b0; settle();
    check("f_i_gnt", {31'd0, i_gnt}, 32'd1);
    check("f_d_gnt", {31'd0, d_gnt}, 32'd0);
    check("f_sram_addr", sram_addr, 32'h1c000000);
    check("f_sram_en_we", {27'd0, sram_en, sram_we}, 32'h10);
    next_cyc(); i_req = 1'b0; settle();
    check("f_i_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd2);
    check("f_i_rdata", i_rdata, 32'hA5000000);

    // Both request: data first, fetch next cycle.
    next_cyc(); i_req = 1'b1; i_addr = 32'h1c000004; d_req = 1'b1; settle();
    check("b_gnt", {30'd0, i_gnt, d_gnt}, 32'd1);
    check("b_sram_addr", sram_addr, 32'h100);
    next_cyc(); d_req = 1'b0; settle();
    check("b_d_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd1);
    check("b_d_rdata", d_rdata, 32'hA5000040);
    check("b_i_gnt", {30'd0, i_gnt, d_gnt}, 32'd2);
    check("b_i_addr", sram_addr, 32'h1c000004);

    // Fetch response stalled 3 cycles with both requesting.
    next_cyc(); i_rready = 1'b0; i_addr = 32'h1c000008; d_req = 1'b1; d_addr = 32'h104;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) next_cyc();
      settle();
      check("s_i_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd2);
      check("s_i_rdata", i_rdata, 32'hA5000001);
      check("s_no_gnt", {29'd0, sram_en, i_gnt, d_gnt}, 32'd0);
    end
    next_cyc(); i_rready = 1'b1; settle();
    check("s_rel_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd2);
    check("s_rel_rdata", i_rdata, 32'hA5000001);
    check("s_rel_gnt", {29'd0, sram_en, i_gnt, d_gnt}, 32'd5);
    next_cyc(); d_req = 1'b0; settle();
    check("s_d_rdata", d_rdata, 32'hA5000041);
    check("s_d_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd1);
    check("s_i_gnt", {30'd0, i_gnt, d_gnt}, 32'd2);
    next_cyc(); i_req = 1'b0; settle();
    check("s_i_rdata2", i_rdata, 32'hA5000002);
    check("s_i_rvalid2", {30'd0, i_rvalid, d_rvalid}, 32'd2);

    // Full-word write, no response, then read it back.
    next_cyc(); d_req = 1'b1; d_we = 4'hF; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; settle();
    check("w_d_gnt", {31'd0, d_gnt}, 32'd1);
    check("w_sram_we", {28'd0, sram_we}, 32'hF);
    check("w_sram_addr", sram_addr, 32'h200);
    check("w_sram_wdata", sram_wdata, 32'hDEADBEEF);
    next_cyc(); d_we = 4'h0; settle();
    check("w_no_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    check("w_rd_gnt", {31'd0, d_gnt}, 32'd1);
    // Write granted in the cycle the read response is accepted.
    next_cyc(); d_we = 4'h3; d_addr = 32'h204; d_wdata = 32'h00001234; settle();
    check("wr_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    check("wr_d_rdata", d_rdata, 32'hDEADBEEF);
    check("wr_gnt_we", {27'd0, d_gnt, sram_we}, 32'h13);
    next_cyc(); d_req = 1'b0; d_we = 4'h0; settle();
    check("wr_no_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);

    // Both held high for six arbitrations.
    next_cyc(); i_req = 1'b1; i_addr = 32'h1c000000; d_req = 1'b1; d_addr = 32'h100;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) next_cyc();
      settle();
      check($sformatf("st_gnt%0d", k), {30'd0, i_gnt, d_gnt},
            exp_i_pat[k] ? 32'd2 : 32'd1);
    end
    next_cyc(); i_req = 1'b0; d_req = 1'b0;

    // Reset in the cycle after a read grant discards the response.
    next_cyc(); i_req = 1'b1; i_addr = 32'h1c000000; settle();
    check("r_pre_gnt", {31'd0, i_gnt}, 32'd1);
    next_cyc(); resetn = 1'b0; settle();
    check("r_low_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    check("r_low_en_gnt", {29'd0, sram_en, i_gnt, d_gnt}, 32'd0);
    next_cyc(); resetn = 1'b1; i_addr = 32'h1c00000C; settle();
    check("r_rel_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    check("r_rel_gnt", {29'd0, sram_en, i_gnt, d_gnt}, 32'd6);
    next_cyc(); i_req = 1'b0; settle();
    check("r_rel_resp", {30'd0, i_rvalid, d_rvalid}, 32'd2);
    check("r_rel_rdata", i_rdata, 32'hA5000003);

    next_cyc();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
